// File: rtl/pc_branch_seq.sv
// Program-counter sequencer: sequential fetch, conditional/absolute/register
// branches, call/return through a small return-address stack, and halt/resume.
module pc_branch_seq #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [7:0]  RESET_PC    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] br_op,
    input  logic [7:0] cond,
    input  logic [7:0] imm,
    input  logic [7:0] rs,
    input  logic       resume,
    output logic [7:0] pc,
    output logic       flush,
    output logic       halted,
    output logic       stack_err
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BT   = 3'd1;
    localparam logic [2:0] OP_BF   = 3'd2;
    localparam logic [2:0] OP_J    = 3'd3;
    localparam logic [2:0] OP_JR   = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        pc_d;
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic              err_d;
    logic              push;
    logic              flag;
    logic              stack_full;
    logic              stack_empty;
    logic [7:0]        pc_inc;
    logic [7:0]        br_tgt;
    logic [7:0]        stack_top;
    logic [7:0]        stack_mem [STACK_DEPTH];
    logic              unused_cond;

    // Only the low bit of the compare result is the branch flag.
    assign flag        = cond[0];
    assign unused_cond = ^cond[7:1];

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign stack_top   = stack_mem[IDX_W'(sp_q - SP_W'(1))];

    // Signed offset add is plain modulo-256 addition of the raw byte.
    assign pc_inc = pc + 8'd1;
    assign br_tgt = pc_inc + imm;

    // Next-state, next-pc and stack control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        sp_d    = sp_q;
        err_d   = stack_err;
        push    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (op_valid) begin
                    case (br_op)
                        OP_SEQ: pc_d = pc_inc;
                        OP_BT: begin
                            if (flag) begin
                                pc_d    = br_tgt;
                                state_d = ST_FLUSH;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                        OP_BF: begin
                            if (!flag) begin
                                pc_d    = br_tgt;
                                state_d = ST_FLUSH;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                        OP_J: begin
                            pc_d    = imm;
                            state_d = ST_FLUSH;
                        end
                        OP_JR: begin
                            pc_d    = rs;
                            state_d = ST_FLUSH;
                        end
                        OP_CALL: begin
                            pc_d    = imm;
                            state_d = ST_FLUSH;
                            if (stack_full) begin
                                err_d = 1'b1;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + SP_W'(1);
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                err_d = 1'b1;
                                pc_d  = pc_inc;
                            end else begin
                                pc_d    = stack_top;
                                sp_d    = sp_q - SP_W'(1);
                                state_d = ST_FLUSH;
                            end
                        end
                        default: state_d = ST_HALT;
                    endcase
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_HALT: begin
                if (resume) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, pc and status outputs; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc        <= RESET_PC;
            sp_q      <= '0;
            stack_err <= 1'b0;
            flush     <= 1'b0;
            halted    <= 1'b0;
            op_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pc        <= pc_d;
            sp_q      <= sp_d;
            stack_err <= err_d;
            flush     <= (state_d == ST_FLUSH);
            halted    <= (state_d == ST_HALT);
            op_ready  <= (state_d == ST_RUN);
        end
    end

    // Return-address storage carries no reset; only the pointer is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[IDX_W'(sp_q)] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_branch_seq.sv
// Directed bench for pc_branch_seq with a queue-based reference model checked every cycle.
module tb_pc_branch_seq;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] br_op;
    logic [7:0] cond;
    logic [7:0] imm;
    logic [7:0] rs;
    logic       resume;
    logic [7:0] pc;
    logic       flush;
    logic       halted;
    logic       stack_err;

    pc_branch_seq #(.STACK_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .br_op(br_op), .cond(cond), .imm(imm), .rs(rs), .resume(resume),
        .pc(pc), .flush(flush), .halted(halted), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [7:0] m_pc;
    bit         m_flush;
    bit         m_halted;
    bit         m_err;
    logic [7:0] m_stack [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 8'h00;
        m_flush  = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_stack.delete();
    endtask

    // Architectural effect of one clock edge.
    task automatic model_step(input bit v, input logic [2:0] op, input logic [7:0] c,
                              input logic [7:0] im, input logic [7:0] r, input bit res);
        bit taken;
        if (m_flush) begin
            m_flush = 1'b0;
        end else if (m_halted) begin
            if (res) begin
                m_pc     = 8'(m_pc + 8'd1);
                m_halted = 1'b0;
            end
        end else if (v) begin
            case (op)
                3'd1, 3'd2: begin
                    taken = (op == 3'd1) ? c[0] : !c[0];
                    if (taken) begin
                        m_pc    = 8'(m_pc + 8'd1 + im);
                        m_flush = 1'b1;
                    end else begin
                        m_pc = 8'(m_pc + 8'd1);
                    end
                end
                3'd3: begin m_pc = im; m_flush = 1'b1; end
                3'd4: begin m_pc = r;  m_flush = 1'b1; end
                3'd5: begin
                    if (m_stack.size() < int'(DEPTH)) m_stack.push_back(8'(m_pc + 8'd1));
                    else m_err = 1'b1;
                    m_pc    = im;
                    m_flush = 1'b1;
                end
                3'd6: begin
                    if (m_stack.size() == 0) begin
                        m_err = 1'b1;
                        m_pc  = 8'(m_pc + 8'd1);
                    end else begin
                        m_pc    = m_stack.pop_back();
                        m_flush = 1'b1;
                    end
                end
                3'd7: m_halted = 1'b1;
                default: m_pc = 8'(m_pc + 8'd1);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc", pc, m_pc);
            chk("model_flush", 8'(flush), 8'(m_flush));
            chk("model_halted", 8'(halted), 8'(m_halted));
            chk("model_stack_err", 8'(stack_err), 8'(m_err));
            chk("model_op_ready", 8'(op_ready), 8'(!m_flush && !m_halted));
        end
    end

    task automatic cyc(input bit v, input logic [2:0] op, input logic [7:0] c,
                       input logic [7:0] im, input logic [7:0] r, input bit res);
        op_valid = v; br_op = op; cond = c; imm = im; rs = r; resume = res;
        @(posedge clk);
        model_step(v, op, c, im, r, res);
        @(negedge clk);
        op_valid = 1'b0;
        resume   = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_op_ready", 8'(op_ready), 8'h01);
        chk("rst_flush", 8'(flush), 8'h00);
        chk("rst_halted", 8'(halted), 8'h00);
        chk("rst_stack_err", 8'(stack_err), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] call_tg [4];
        logic [7:0] ret_tg  [4];
        call_tg = '{8'h40, 8'h50, 8'h60, 8'h70};
        ret_tg  = '{8'h62, 8'h52, 8'h42, 8'h02};
        rst_n = 1'b1; op_valid = 1'b0; br_op = 3'd0; cond = 8'h00;
        imm = 8'h00; rs = 8'h00; resume = 1'b0;
        model_reset();
        do_reset();
        chk_en = 1'b1;

        // Sequential wrap through the whole address space.
        repeat (256) cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("wrap_pc", pc, 8'h00);
        repeat (16) cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("seq_pc10", pc, 8'h10);

        // Conditional branches.
        cyc(1, 3'd1, 8'h01, 8'hFC, 8'h00, 0);
        chk("bt_taken_pc", pc, 8'h0D);
        chk("bt_taken_flush", 8'(flush), 8'h01);
        chk("bt_taken_ready", 8'(op_ready), 8'h00);
        cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("flush_ignores_op", pc, 8'h0D);
        chk("flush_one_cycle", 8'(flush), 8'h00);
        repeat (3) cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 3'd1, 8'hFE, 8'hFC, 8'h00, 0);
        chk("bt_not_taken_pc", pc, 8'h11);
        chk("bt_not_taken_flush", 8'(flush), 8'h00);
        cyc(1, 3'd2, 8'h00, 8'h05, 8'h00, 0);
        chk("bf_taken_pc", pc, 8'h17);
        cyc(0, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 3'd2, 8'h01, 8'h05, 8'h00, 0);
        chk("bf_not_taken_pc", pc, 8'h18);

        // Stack overflow then drain.
        do_reset();
        cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 3'd5, 8'h00, call_tg[i], 8'h00, 0);
            chk("call_pc", pc, call_tg[i]);
            cyc(0, 3'd0, 8'h00, 8'h00, 8'h00, 0);
            if (i < 3) cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        end
        chk("stack_err_before_ovf", 8'(stack_err), 8'h00);
        cyc(1, 3'd5, 8'h00, 8'h80, 8'h00, 0);
        chk("ovf_pc", pc, 8'h80);
        chk("ovf_err", 8'(stack_err), 8'h01);
        cyc(0, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
            chk("ret_pc", pc, ret_tg[i]);
            cyc(0, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        end
        cyc(1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("ret_empty_pc", pc, 8'h03);

        // Underflow on an empty stack.
        do_reset();
        repeat (5) cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("pre_unf_pc", pc, 8'h05);
        cyc(1, 3'd6, 8'h00, 8'h00, 8'h00, 0);
        chk("unf_pc", pc, 8'h06);
        chk("unf_err", 8'(stack_err), 8'h01);
        chk("unf_flush", 8'(flush), 8'h00);
        cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("unf_err_sticky", 8'(stack_err), 8'h01);

        // Halt and resume.
        cyc(1, 3'd3, 8'h00, 8'h20, 8'h00, 0);
        cyc(0, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 3'd7, 8'h00, 8'h00, 8'h00, 0);
        chk("halt_halted", 8'(halted), 8'h01);
        chk("halt_ready", 8'(op_ready), 8'h00);
        repeat (10) cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("halt_pc_held", pc, 8'h20);
        cyc(0, 3'd0, 8'h00, 8'h00, 8'h00, 1);
        chk("resume_pc", pc, 8'h21);
        chk("resume_halted", 8'(halted), 8'h00);
        chk("resume_ready", 8'(op_ready), 8'h01);

        // Asynchronous reset in the middle of a flush.
        cyc(1, 3'd4, 8'h00, 8'h00, 8'hAA, 0);
        chk("jr_pc", pc, 8'hAA);
        chk("jr_flush", 8'(flush), 8'h01);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", pc, 8'h00);
        chk("async_rst_flush", 8'(flush), 8'h00);
        chk("async_rst_ready", 8'(op_ready), 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 3'd0, 8'h00, 8'h00, 8'h00, 0);
        chk("post_rst_first_accept", pc, 8'h01);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
